// File: rtl/crossbar_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_v2_pkg
// Description : Shared constants for the crossbar_v2 operand crossbar:
//               action-word field positions, opcode encodings, default class
//               widths, the lane select mode type and an index-width helper.
// Revision    : 2.0 - generic container count, handshake, 2-stage pipeline
// ============================================================================
package crossbar_v2_pkg;

   // Action word field layout
   localparam int unsigned ACT_OP_MSB   = 24;
   localparam int unsigned ACT_OP_LSB   = 21;
   localparam int unsigned ACT_IDX1_LSB = 16;
   localparam int unsigned ACT_IDX2_LSB = 11;
   localparam int unsigned ACT_IMM_LSB  = 0;
   localparam int unsigned OP_W         = 4;

   // Opcode encodings
   localparam logic [OP_W-1:0] OP_NOP     = 4'b0000;
   localparam int unsigned     OP_IMM_BIT = 3;

   // Default container widths per class
   localparam int unsigned CLS_W6 = 48;
   localparam int unsigned CLS_W4 = 32;
   localparam int unsigned CLS_W2 = 16;

   // How a lane picks its two operands
   typedef enum logic [1:0] {
      SEL_OWN  = 2'd0,   // own container, operand 2 is zero
      SEL_IMM  = 2'd1,   // indexed container, operand 2 is the immediate
      SEL_CONT = 2'd2    // two indexed containers
   } sel_mode_e;

   // Ceiling log2 with a floor of one bit so a select is never zero wide
   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crossbar_v2_lane_sel.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_v2_lane_sel
// Description : Operand selection for one ALU lane of one width class.
//               Decodes the lane's action word and picks operand 1 / operand 2
//               from the class's container vector or the action immediate.
//               Purely combinational.
// Revision    : 2.0 - parametrised width and container count
// ============================================================================
module crossbar_v2_lane_sel
   import crossbar_v2_pkg::*;
#(
   parameter int unsigned W       = 48,
   parameter int unsigned C_NUM   = 8,
   parameter int unsigned ACT_LEN = 25,
   parameter int unsigned IMM_W   = 16,
   parameter int unsigned IDX_W   = idx_width(C_NUM)
) (
   input  logic [C_NUM*W-1:0] cont_i,
   input  logic [IDX_W-1:0]   own_idx_i,
   input  logic [ACT_LEN-1:0] act_i,
   output logic [W-1:0]       op1_o,
   output logic [W-1:0]       op2_o
);

   logic [W-1:0]      cont [C_NUM];
   logic [OP_W-1:0]   op;
   logic [IDX_W-1:0]  idx1;
   logic [IDX_W-1:0]  idx2;
   logic [W-1:0]      imm_ext;
   sel_mode_e         mode;
   logic              unused_act;

   for (genvar i = 0; i < C_NUM; i++) begin : g_unpack
      assign cont[i] = cont_i[i*W +: W];
   end

   // Upper index bits are deliberately ignored; only log2(C_NUM) bits select
   assign op         = act_i[ACT_OP_MSB:ACT_OP_LSB];
   assign idx1       = act_i[ACT_IDX1_LSB +: IDX_W];
   assign idx2       = act_i[ACT_IDX2_LSB +: IDX_W];
   assign unused_act = ^act_i;

   // Classify the opcode into a select mode
   always_comb begin
      mode = SEL_CONT;
      if (op == OP_NOP) begin
         mode = SEL_OWN;
      end else if (op[OP_IMM_BIT]) begin
         mode = SEL_IMM;
      end
   end

   // Zero-extend the immediate to the class width
   always_comb begin
      imm_ext              = '0;
      imm_ext[IMM_W-1:0]   = act_i[ACT_IMM_LSB +: IMM_W];
   end

   // Operand multiplexers
   always_comb begin
      op1_o = cont[idx1];
      op2_o = cont[idx2];
      case (mode)
         SEL_OWN: begin
            op1_o = cont[own_idx_i];
            op2_o = '0;
         end
         SEL_IMM: begin
            op2_o = imm_ext;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/crossbar_v2.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_v2
// Description : Operand crossbar between the PHV/action path and the ALU array
//               of one match-action stage. Two-stage valid/ready pipeline:
//               S1 captures PHV + action words, S2 captures muxed operands.
//               Optional statistics counters built when CROSSBAR_V2_STATS_EN
//               is defined; otherwise the stat ports are tied to zero.
// Revision    : 2.0 - generic widths, backpressure, unpaired-input detection
// ============================================================================
module crossbar_v2
   import crossbar_v2_pkg::*;
#(
   parameter int unsigned STAGE    = 0,
   parameter int unsigned C_NUM    = 8,
   parameter int unsigned W6       = CLS_W6,
   parameter int unsigned W4       = CLS_W4,
   parameter int unsigned W2       = CLS_W2,
   parameter int unsigned META_LEN = 356,
   parameter int unsigned ACT_LEN  = 25,
   parameter int unsigned IMM_W    = 16,
   parameter int unsigned NUM_ACT  = 3*C_NUM + 1,
   parameter int unsigned PHV_LEN  = C_NUM*(W6+W4+W2) + META_LEN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PHV_LEN-1:0]         phv_in,
   input  logic                       phv_in_valid,
   input  logic [ACT_LEN*NUM_ACT-1:0] action_in,
   input  logic                       action_in_valid,
   output logic                       in_ready,
   output logic                       alu_in_valid,
   input  logic                       out_ready,
   output logic [C_NUM*W6-1:0]        alu_in_6B_1,
   output logic [C_NUM*W6-1:0]        alu_in_6B_2,
   output logic [C_NUM*W4-1:0]        alu_in_4B_1,
   output logic [C_NUM*W4-1:0]        alu_in_4B_2,
   output logic [C_NUM*W2-1:0]        alu_in_2B_1,
   output logic [C_NUM*W2-1:0]        alu_in_2B_2,
   output logic [ACT_LEN*NUM_ACT-1:0] alu_action,
   output logic [META_LEN-1:0]        phv_remain_data,
   output logic                       err_unpaired,
   output logic [31:0]                stat_pkt_cnt,
   output logic [31:0]                stat_imm_cnt
);

   localparam int unsigned IDX_W   = idx_width(C_NUM);
   localparam int unsigned ACT_TOT = ACT_LEN*NUM_ACT;
   localparam int unsigned c_off2  = META_LEN;
   localparam int unsigned c_off4  = META_LEN + C_NUM*W2;
   localparam int unsigned c_off6  = c_off4 + C_NUM*W4;
   localparam int unsigned c_stage_unused = STAGE;

   logic                 rdy_q;
   logic                 s1_valid_q;
   logic [PHV_LEN-1:0]   s1_phv_q;
   logic [ACT_TOT-1:0]   s1_act_q;
   logic                 s2_valid_q;
   logic [C_NUM*W6-1:0]  s2_6b_1_q, s2_6b_2_q;
   logic [C_NUM*W4-1:0]  s2_4b_1_q, s2_4b_2_q;
   logic [C_NUM*W2-1:0]  s2_2b_1_q, s2_2b_2_q;
   logic [ACT_TOT-1:0]   s2_act_q;
   logic [META_LEN-1:0]  s2_meta_q;

   logic [C_NUM*W6-1:0]  mux_6b_1, mux_6b_2;
   logic [C_NUM*W4-1:0]  mux_4b_1, mux_4b_2;
   logic [C_NUM*W2-1:0]  mux_2b_1, mux_2b_2;
   logic                 s2_ready;
   logic                 accept;

   // S2 can take a new beat when it is empty or its beat leaves this cycle
   assign s2_ready     = !s2_valid_q || out_ready;
   // rdy_q keeps the input closed during reset and opens it one edge later
   assign in_ready     = rdy_q && (!s1_valid_q || s2_ready);
   assign accept       = phv_in_valid && action_in_valid && in_ready;
   assign err_unpaired = (phv_in_valid ^ action_in_valid) && in_ready;

   // Input-enable flag released on the first edge after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= 1'b1;
   end

   // S1: capture a paired PHV/action beat, hold while S2 is blocked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_phv_q   <= '0;
         s1_act_q   <= '0;
      end else if (in_ready) begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_phv_q <= phv_in;
            s1_act_q <= action_in;
         end
      end
   end

   // Per-lane operand selection; lanes never cross width classes
   for (genvar k = 0; k < C_NUM; k++) begin : g_lane
      localparam logic [IDX_W-1:0] c_own_idx = IDX_W'(k);

      crossbar_v2_lane_sel #(
         .W(W6), .C_NUM(C_NUM), .ACT_LEN(ACT_LEN), .IMM_W(IMM_W), .IDX_W(IDX_W)
      ) u_sel6 (
         .cont_i    (s1_phv_q[c_off6 +: C_NUM*W6]),
         .own_idx_i (c_own_idx),
         .act_i     (s1_act_q[(1 + 2*C_NUM + k)*ACT_LEN +: ACT_LEN]),
         .op1_o     (mux_6b_1[k*W6 +: W6]),
         .op2_o     (mux_6b_2[k*W6 +: W6])
      );

      crossbar_v2_lane_sel #(
         .W(W4), .C_NUM(C_NUM), .ACT_LEN(ACT_LEN), .IMM_W(IMM_W), .IDX_W(IDX_W)
      ) u_sel4 (
         .cont_i    (s1_phv_q[c_off4 +: C_NUM*W4]),
         .own_idx_i (c_own_idx),
         .act_i     (s1_act_q[(1 + C_NUM + k)*ACT_LEN +: ACT_LEN]),
         .op1_o     (mux_4b_1[k*W4 +: W4]),
         .op2_o     (mux_4b_2[k*W4 +: W4])
      );

      crossbar_v2_lane_sel #(
         .W(W2), .C_NUM(C_NUM), .ACT_LEN(ACT_LEN), .IMM_W(IMM_W), .IDX_W(IDX_W)
      ) u_sel2 (
         .cont_i    (s1_phv_q[c_off2 +: C_NUM*W2]),
         .own_idx_i (c_own_idx),
         .act_i     (s1_act_q[(1 + k)*ACT_LEN +: ACT_LEN]),
         .op1_o     (mux_2b_1[k*W2 +: W2]),
         .op2_o     (mux_2b_2[k*W2 +: W2])
      );
   end

   // S2: register muxed operands with aligned actions and metadata
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_6b_1_q  <= '0;
         s2_6b_2_q  <= '0;
         s2_4b_1_q  <= '0;
         s2_4b_2_q  <= '0;
         s2_2b_1_q  <= '0;
         s2_2b_2_q  <= '0;
         s2_act_q   <= '0;
         s2_meta_q  <= '0;
      end else if (s2_ready) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_6b_1_q <= mux_6b_1;
            s2_6b_2_q <= mux_6b_2;
            s2_4b_1_q <= mux_4b_1;
            s2_4b_2_q <= mux_4b_2;
            s2_2b_1_q <= mux_2b_1;
            s2_2b_2_q <= mux_2b_2;
            s2_act_q  <= s1_act_q;
            s2_meta_q <= s1_phv_q[META_LEN-1:0];
         end
      end
   end

   assign alu_in_valid    = s2_valid_q;
   assign alu_in_6B_1     = s2_6b_1_q;
   assign alu_in_6B_2     = s2_6b_2_q;
   assign alu_in_4B_1     = s2_4b_1_q;
   assign alu_in_4B_2     = s2_4b_2_q;
   assign alu_in_2B_1     = s2_2b_1_q;
   assign alu_in_2B_2     = s2_2b_2_q;
   assign alu_action      = s2_act_q;
   assign phv_remain_data = s2_meta_q;

`ifdef CROSSBAR_V2_STATS_EN
   logic        out_hs;
   logic [7:0]  imm_lanes;
   logic [32:0] imm_sum;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [31:0] imm_cnt_q, imm_cnt_d;

   assign out_hs = s2_valid_q && out_ready;

   // Count immediate-mode lanes in the beat at the output (metadata word excluded)
   always_comb begin
      imm_lanes = '0;
      for (int i = 1; i < NUM_ACT; i++) begin
         imm_lanes = imm_lanes + {7'd0, s2_act_q[i*ACT_LEN + ACT_OP_LSB + OP_IMM_BIT]};
      end
   end

   // Saturating next-state for both counters
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      imm_cnt_d = imm_cnt_q;
      imm_sum   = {1'b0, imm_cnt_q} + {25'd0, imm_lanes};
      if (out_hs) begin
         if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_d = pkt_cnt_q + 32'd1;
         imm_cnt_d = imm_sum[32] ? 32'hFFFF_FFFF : imm_sum[31:0];
      end
   end

   // Statistics counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt_q <= '0;
         imm_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         imm_cnt_q <= imm_cnt_d;
      end
   end

   assign stat_pkt_cnt = pkt_cnt_q;
   assign stat_imm_cnt = imm_cnt_q;
`else
   assign stat_pkt_cnt = '0;
   assign stat_imm_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crossbar_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_crossbar_v2
// Description : Self-checking bench for crossbar_v2. Directed scenarios plus
//               randomized traffic checked against a queue-based reference
//               model of the operand selection rules.
// Revision    : 2.0
// ============================================================================
module tb_crossbar_v2;

   localparam int C   = 8;
   localparam int W6  = 48;
   localparam int W4  = 32;
   localparam int W2  = 16;
   localparam int ML  = 356;
   localparam int AL  = 25;
   localparam int NA  = 3*C + 1;
   localparam int PL  = C*(W6+W4+W2) + ML;
   localparam int AT  = AL*NA;
   localparam int CW  = 1280;

   typedef struct {
      logic [383:0]  o1 [3];   // class 0 = 2B, 1 = 4B, 2 = 6B
      logic [383:0]  o2 [3];
      logic [AT-1:0] act;
      logic [ML-1:0] meta;
      int            imm_lanes;
   } beat_t;

   logic            clk;
   logic            rst;
   logic [PL-1:0]   phv_in;
   logic            phv_in_valid;
   logic [AT-1:0]   action_in;
   logic            action_in_valid;
   logic            in_ready;
   logic            alu_in_valid;
   logic            out_ready;
   logic [C*W6-1:0] alu_in_6B_1, alu_in_6B_2;
   logic [C*W4-1:0] alu_in_4B_1, alu_in_4B_2;
   logic [C*W2-1:0] alu_in_2B_1, alu_in_2B_2;
   logic [AT-1:0]   alu_action;
   logic [ML-1:0]   phv_remain_data;
   logic            err_unpaired;
   logic [31:0]     stat_pkt_cnt, stat_imm_cnt;

   int      n_vec = 0;
   int      n_err = 0;
   int      n_out = 0;
   longint  m_pkt = 0;
   longint  m_imm = 0;
   beat_t   exp_q [$];
   beat_t   mb;

   crossbar_v2 dut (
      .clk(clk), .rst(rst),
      .phv_in(phv_in), .phv_in_valid(phv_in_valid),
      .action_in(action_in), .action_in_valid(action_in_valid),
      .in_ready(in_ready), .alu_in_valid(alu_in_valid), .out_ready(out_ready),
      .alu_in_6B_1(alu_in_6B_1), .alu_in_6B_2(alu_in_6B_2),
      .alu_in_4B_1(alu_in_4B_1), .alu_in_4B_2(alu_in_4B_2),
      .alu_in_2B_1(alu_in_2B_1), .alu_in_2B_2(alu_in_2B_2),
      .alu_action(alu_action), .phv_remain_data(phv_remain_data),
      .err_unpaired(err_unpaired),
      .stat_pkt_cnt(stat_pkt_cnt), .stat_imm_cnt(stat_imm_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic int cls_w(input int cls);
      return (cls == 0) ? W2 : (cls == 1) ? W4 : W6;
   endfunction

   function automatic int cls_base(input int cls);
      return (cls == 0) ? ML : (cls == 1) ? ML + C*W2 : ML + C*(W2+W4);
   endfunction

   // Reference model: containers and action words read by arithmetic position
   function automatic beat_t model(input logic [PL-1:0] phv, input logic [AT-1:0] act);
      beat_t        b;
      logic [47:0]  cont [3][C];
      logic [47:0]  mask, a, o;
      logic [24:0]  w;
      int           op, i1, i2;
      b.imm_lanes = 0;
      for (int cls = 0; cls < 3; cls++) begin
         mask = (48'd1 << cls_w(cls)) - 48'd1;
         b.o1[cls] = '0;
         b.o2[cls] = '0;
         for (int j = 0; j < C; j++)
            cont[cls][j] = 48'(phv >> (cls_base(cls) + j*cls_w(cls))) & mask;
         for (int k = 0; k < C; k++) begin
            w  = 25'(act >> ((1 + cls*C + k)*AL));
            op = int'(w[24:21]);
            i1 = int'(w[20:16]) % C;
            i2 = int'(w[15:11]) % C;
            if (op == 0) begin
               a = cont[cls][k];
               o = '0;
            end else if (op >= 8) begin
               a = cont[cls][i1];
               o = {32'd0, w[15:0]};
               b.imm_lanes++;
            end else begin
               a = cont[cls][i1];
               o = cont[cls][i2];
            end
            b.o1[cls] = b.o1[cls] | (384'(a) << (k*cls_w(cls)));
            b.o2[cls] = b.o2[cls] | (384'(o) << (k*cls_w(cls)));
         end
      end
      b.act  = act;
      b.meta = phv[ML-1:0];
      return b;
   endfunction

   function automatic logic [CW-1:0] rand_wide();
      logic [CW-1:0] v;
      v = '0;
      for (int i = 0; i < CW/32; i++) v = (v << 32) | CW'($urandom);
      return v;
   endfunction

   // Output monitor / scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_pkt = 0;
         m_imm = 0;
      end else begin
`ifdef CROSSBAR_V2_STATS_EN
         check("stat_pkt", CW'(stat_pkt_cnt), CW'(m_pkt));
         check("stat_imm", CW'(stat_imm_cnt), CW'(m_imm));
`else
         check("stat_pkt_off", CW'(stat_pkt_cnt), '0);
         check("stat_imm_off", CW'(stat_imm_cnt), '0);
`endif
         check("err_unpaired", CW'(err_unpaired), CW'((phv_in_valid ^ action_in_valid) & in_ready));
         if (alu_in_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_beat", CW'(alu_in_valid), '0);
            end else begin
               mb = exp_q[0];
               check("op6_1", CW'(alu_in_6B_1), CW'(mb.o1[2]));
               check("op6_2", CW'(alu_in_6B_2), CW'(mb.o2[2]));
               check("op4_1", CW'(alu_in_4B_1), CW'(mb.o1[1]));
               check("op4_2", CW'(alu_in_4B_2), CW'(mb.o2[1]));
               check("op2_1", CW'(alu_in_2B_1), CW'(mb.o1[0]));
               check("op2_2", CW'(alu_in_2B_2), CW'(mb.o2[0]));
               check("action", CW'(alu_action), CW'(mb.act));
               check("meta", CW'(phv_remain_data), CW'(mb.meta));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
                  if (m_pkt < 64'hFFFF_FFFF) m_pkt++;
                  m_imm = m_imm + mb.imm_lanes;
                  if (m_imm > 64'hFFFF_FFFF) m_imm = 64'hFFFF_FFFF;
               end
            end
         end
         if (phv_in_valid && action_in_valid && in_ready)
            exp_q.push_back(model(phv_in, action_in));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [PL-1:0] p, input logic [AT-1:0] a);
      int t;
      phv_in = p;
      action_in = a;
      phv_in_valid = 1'b1;
      action_in_valid = 1'b1;
      #1;
      t = 0;
      while (!in_ready && t < 50) begin
         step();
         t++;
      end
      check("send_ready", CW'(in_ready), CW'(1));
      step();
      phv_in_valid = 1'b0;
      action_in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!alu_in_valid && t < 10) begin
         step();
         t++;
      end
      check("out_valid", CW'(alu_in_valid), CW'(1));
   endtask

   task automatic drain();
      int t;
      out_ready = 1'b1;
      phv_in_valid = 1'b0;
      action_in_valid = 1'b0;
      t = 0;
      while ((exp_q.size() != 0 || alu_in_valid) && t < 50) begin
         step();
         t++;
      end
      check("drain_empty", CW'(exp_q.size()), '0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   logic [PL-1:0] p;
   logic [AT-1:0] a;
   logic [AL-1:0] w;
   int            base;

   initial begin : main
      rst = 1'b1;
      phv_in = '0;
      action_in = '0;
      phv_in_valid = 1'b0;
      action_in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();

      // Reset state
      check("rst_valid", CW'(alu_in_valid), '0);
      check("rst_in_ready", CW'(in_ready), '0);
      check("rst_err", CW'(err_unpaired), '0);
      check("rst_6B_1", CW'(alu_in_6B_1), '0);
      check("rst_2B_2", CW'(alu_in_2B_2), '0);
      check("rst_action", CW'(alu_action), '0);
      check("rst_meta", CW'(phv_remain_data), '0);
      check("rst_stat_pkt", CW'(stat_pkt_cnt), '0);
      rst = 1'b0;
      step();
      check("rdy_after_rst", CW'(in_ready), CW'(1));

      // Container mode
      p = PL'(rand_wide());
      p[ML + C*(W2+W4) + 7*W6 +: W6] = 48'hfffffffffffe;
      p[ML + C*(W2+W4) + 6*W6 +: W6] = 48'heeeeeeeeeeef;
      a = '0;
      w = {4'b0001, 5'd6, 5'd7, 11'd0};
      a[(1 + 2*C + 7)*AL +: AL] = w;
      send_beat(p, a);
      check("cont_latency", CW'(alu_in_valid), '0);
      wait_valid();
      check("cont_op1", CW'(alu_in_6B_1[7*W6 +: W6]), CW'(48'heeeeeeeeeeef));
      check("cont_op2", CW'(alu_in_6B_2[7*W6 +: W6]), CW'(48'hfffffffffffe));
      step();

      // Immediate mode
      p = PL'(rand_wide());
      p[ML + C*(W2+W4) + 6*W6 +: W6] = 48'heeeeeeeeeeee;
      a = '0;
      w = {4'b1010, 5'd6, 16'hffff};
      a[(1 + 2*C + 7)*AL +: AL] = w;
      send_beat(p, a);
      wait_valid();
      check("imm_op1", CW'(alu_in_6B_1[7*W6 +: W6]), CW'(48'heeeeeeeeeeee));
      check("imm_op2", CW'(alu_in_6B_2[7*W6 +: W6]), CW'(48'h00000000ffff));
      step();
`ifdef CROSSBAR_V2_STATS_EN
      check("imm_stat", CW'(stat_imm_cnt), CW'(1));
`endif

      // NOP: own container, zero operand 2, pass-through of action and meta
      p = PL'(rand_wide());
      p[ML + C*(W2+W4) + 7*W6 +: W6] = 48'hffffffffffff;
      a = AT'(rand_wide());
      w = {4'b0000, 5'd3, 5'd2, 11'h5a};
      a[(1 + 2*C + 7)*AL +: AL] = w;
      send_beat(p, a);
      wait_valid();
      check("nop_op1", CW'(alu_in_6B_1[7*W6 +: W6]), CW'(48'hffffffffffff));
      check("nop_op2", CW'(alu_in_6B_2[7*W6 +: W6]), '0);
      check("nop_action", CW'(alu_action), CW'(a));
      check("nop_meta", CW'(phv_remain_data), CW'(p[ML-1:0]));
      drain();

      // Backpressure: 4 beats, out_ready low for 3 cycles
      do_reset();
      base = n_out;
      out_ready = 1'b0;
      send_beat(PL'(rand_wide()), AT'(rand_wide()));
      send_beat(PL'(rand_wide()), AT'(rand_wide()));
      p = PL'(rand_wide());
      a = AT'(rand_wide());
      phv_in = p;
      action_in = a;
      phv_in_valid = 1'b1;
      action_in_valid = 1'b1;
      #1;
      check("bp_ready_low", CW'(in_ready), '0);
      step();
      check("bp_ready_low2", CW'(in_ready), '0);
      check("bp_valid_held", CW'(alu_in_valid), CW'(1));
      out_ready = 1'b1;
      send_beat(p, a);
      send_beat(PL'(rand_wide()), AT'(rand_wide()));
      drain();
      check("bp_beats_out", CW'(n_out - base), CW'(4));
`ifdef CROSSBAR_V2_STATS_EN
      check("bp_stat_pkt", CW'(stat_pkt_cnt), CW'(4));
`endif

      // Unpaired input for two cycles, then pairing completes
      base = n_out;
      phv_in = PL'(rand_wide());
      action_in = AT'(rand_wide());
      phv_in_valid = 1'b1;
      action_in_valid = 1'b0;
      #1;
      check("unp_err_1", CW'(err_unpaired), CW'(1));
      step();
      check("unp_err_2", CW'(err_unpaired), CW'(1));
      step();
      action_in_valid = 1'b1;
      #1;
      check("unp_err_clear", CW'(err_unpaired), '0);
      step();
      phv_in_valid = 1'b0;
      action_in_valid = 1'b0;
      drain();
      check("unp_one_beat", CW'(n_out - base), CW'(1));

      // Reset with two beats in flight
      base = n_out;
      send_beat(PL'(rand_wide()), AT'(rand_wide()));
      send_beat(PL'(rand_wide()), AT'(rand_wide()));
      rst = 1'b1;
      #1;
      check("mrst_valid", CW'(alu_in_valid), '0);
      check("mrst_in_ready", CW'(in_ready), '0);
      step();
      rst = 1'b0;
      #1;
      check("mrst_ready_before_edge", CW'(in_ready), '0);
      step();
      check("mrst_ready_after_edge", CW'(in_ready), CW'(1));
      repeat (4) begin
         step();
         check("mrst_no_output", CW'(alu_in_valid), '0);
      end
      check("mrst_no_beats", CW'(n_out - base), '0);

      // Randomized traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         phv_in = PL'(rand_wide());
         action_in = AT'(rand_wide());
         phv_in_valid = ($urandom_range(0, 3) != 0);
         action_in_valid = phv_in_valid ? ($urandom_range(0, 7) != 0)
                                        : ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
